pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 29 ++
 rtl/pc_sequencer_ras.sv | 83 ++++++++
 rtl/pc_sequencer.sv | 91 +++++++++
 tb/tb_pc_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared constants and width helpers for the program-counter sequencer and its
// return-address stack.
package pc_sequencer_pkg;

    localparam int DEF_PC_W      = 32;
    localparam int DEF_IMEM_AW   = 12;
    localparam int DEF_UPPER_W   = 5;
    localparam int DEF_STEP      = 1;
    localparam int DEF_RESET_VEC = 0;
    localparam int DEF_RAS_DEPTH = 4;

    // Stack pointer width; a depth of 1 would still need one index bit.
    function automatic int ras_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Entry count must represent 0..depth inclusive.
    function automatic int ras_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef enum logic [1:0] {
        SEL_SEQ  = 2'd0,
        SEL_JUMP = 2'd1,
        SEL_CALL = 2'd2,
        SEL_RET  = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack: a full push overwrites the oldest entry, and a
// pop on an empty stack only raises an underflow pulse.
module pc_ras
    import pc_sequencer_pkg::*;
#(
    parameter int W     = DEF_PC_W,
    parameter int DEPTH = DEF_RAS_DEPTH,
    localparam int IW   = ras_idx_w(DEPTH),
    localparam int CW   = ras_cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  push_data_i,
    output logic [W-1:0]  top_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          overflow_o,
    output logic          underflow_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [IW-1:0] sp_q, sp_d;
    logic [IW-1:0] top_idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    // sp_q is the next write slot; once full, that slot holds the oldest entry.
    assign top_idx = sp_q - IW'(1);
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        sp_d  = sp_q;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (push_i) begin
            sp_d = sp_q + IW'(1);
            if (full_o) ovf_d = 1'b1;
            else        cnt_d = cnt_q + CW'(1);
        end else if (pop_i) begin
            if (empty_o) begin
                unf_d = 1'b1;
            end else begin
                sp_d  = top_idx;
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // NOTE: entry storage is deliberately not reset; the count gates every read,
    // and leaving it out of reset lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[sp_q] <= push_data_i;
    end

    assign top_o       = mem_q[top_idx];
    assign count_o     = cnt_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: prioritised next-PC selection (jump > call > ret >
// sequential) with a return-address stack for call/ret.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              PC_W      = DEF_PC_W,
    parameter int              IMEM_AW   = DEF_IMEM_AW,
    parameter int              UPPER_W   = DEF_UPPER_W,
    parameter int              STEP      = DEF_STEP,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(DEF_RESET_VEC),
    parameter int              RAS_DEPTH = DEF_RAS_DEPTH,
    localparam int             CW        = ras_cnt_w(RAS_DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pc_ena_i,
    input  logic               jump_i,
    input  logic               call_i,
    input  logic               ret_i,
    input  logic [PC_W-1:0]    target_i,
    output logic [PC_W-1:0]    pc_out_o,
    output logic [PC_W-1:0]    pc_plus_o,
    output logic [IMEM_AW-1:0] address_imem_o,
    output logic [UPPER_W-1:0] pc_upper_o,
    output logic [CW-1:0]      ras_count_o,
    output logic               ras_empty_o,
    output logic               ras_full_o,
    output logic               ras_overflow_o,
    output logic               ras_underflow_o
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_plus;
    logic [PC_W-1:0] ras_top;
    logic            ras_empty;
    logic            push, pop;
    pc_sel_e         sel;

    assign pc_plus = pc_q + PC_W'(STEP);

    always_comb begin
        sel = SEL_SEQ;
        if      (jump_i) sel = SEL_JUMP;
        else if (call_i) sel = SEL_CALL;
        else if (ret_i)  sel = SEL_RET;
    end

    // Losing commands are dropped entirely: only the winner touches the stack.
    assign push = pc_ena_i && (sel == SEL_CALL);
    assign pop  = pc_ena_i && (sel == SEL_RET);

    always_comb begin
        pc_d = pc_q;
        if (pc_ena_i) begin
            unique case (sel)
                SEL_JUMP, SEL_CALL: pc_d = target_i;
                SEL_RET:            pc_d = ras_empty ? pc_plus : ras_top;
                default:            pc_d = pc_plus;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_VEC;
        else        pc_q <= pc_d;
    end

    pc_ras #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (pc_plus),
        .top_o       (ras_top),
        .count_o     (ras_count_o),
        .empty_o     (ras_empty),
        .full_o      (ras_full_o),
        .overflow_o  (ras_overflow_o),
        .underflow_o (ras_underflow_o)
    );

    assign pc_out_o       = pc_q;
    assign pc_plus_o      = pc_plus;
    assign address_imem_o = pc_q[IMEM_AW-1:0];
    assign pc_upper_o     = pc_q[PC_W-1 -: UPPER_W];
    assign ras_empty_o    = ras_empty;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed commands push hand-computed
// post-edge state; a monitor pops and compares after each rising edge.
module tb_pc_sequencer;

    localparam int CW = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_ena, jump, call, ret;
    logic [31:0] target;
    logic [31:0] pc_out, pc_plus;
    logic [11:0] address_imem;
    logic [4:0]  pc_upper;
    logic [CW-1:0] ras_count;
    logic        ras_empty, ras_full, ras_overflow, ras_underflow;

    // Narrow instance for the 8-bit wrap case.
    logic        e8, j8;
    logic [7:0]  t8, pc8, pp8;
    logic [3:0]  ad8;
    logic [2:0]  up8;
    logic [1:0]  cnt8;
    logic        em8, fu8, ov8, un8;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [CW-1:0] cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .pc_ena_i(pc_ena), .jump_i(jump), .call_i(call),
        .ret_i(ret), .target_i(target), .pc_out_o(pc_out), .pc_plus_o(pc_plus),
        .address_imem_o(address_imem), .pc_upper_o(pc_upper), .ras_count_o(ras_count),
        .ras_empty_o(ras_empty), .ras_full_o(ras_full), .ras_overflow_o(ras_overflow),
        .ras_underflow_o(ras_underflow)
    );

    pc_sequencer #(.PC_W(8), .IMEM_AW(4), .UPPER_W(3), .RAS_DEPTH(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .pc_ena_i(e8), .jump_i(j8), .call_i(1'b0),
        .ret_i(1'b0), .target_i(t8), .pc_out_o(pc8), .pc_plus_o(pp8),
        .address_imem_o(ad8), .pc_upper_o(up8), .ras_count_o(cnt8),
        .ras_empty_o(em8), .ras_full_o(fu8), .ras_overflow_o(ov8),
        .ras_underflow_o(un8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs applied at a falling edge; expected state is what follows the next rising edge.
    task automatic step(input string tag, input logic ena, input logic j, input logic c,
                        input logic r, input logic [31:0] tgt, input logic [31:0] exp_pc,
                        input logic [CW-1:0] exp_cnt, input logic exp_ovf, input logic exp_unf);
        exp_t e;
        pc_ena = ena; jump = j; call = c; ret = r; target = tgt;
        e.tag = tag; e.pc = exp_pc; e.cnt = exp_cnt; e.ovf = exp_ovf; e.unf = exp_unf;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        logic [31:0] pc_p1;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                pc_p1 = e.pc + 32'd1;
                check({e.tag, ".pc_out"},   pc_out,        e.pc);
                check({e.tag, ".pc_plus"},  pc_plus,       pc_p1);
                check({e.tag, ".addr"},     address_imem,  e.pc[11:0]);
                check({e.tag, ".upper"},    pc_upper,      e.pc[31:27]);
                check({e.tag, ".count"},    ras_count,     e.cnt);
                check({e.tag, ".empty"},    ras_empty,     e.cnt == 0);
                check({e.tag, ".full"},     ras_full,      e.cnt == 4);
                check({e.tag, ".overflow"}, ras_overflow,  e.ovf);
                check({e.tag, ".underflow"},ras_underflow, e.unf);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        pc_ena = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0; target = '0;
        e8 = 1'b0; j8 = 1'b0; t8 = '0;
        #3;
        check("reset.pc",    pc_out,        32'd0);
        check("reset.count", ras_count,     0);
        check("reset.empty", ras_empty,     1);
        check("reset.ovf",   ras_overflow,  0);
        check("reset.unf",   ras_underflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("release.pc", pc_out, 32'd0);

        // Sequential fetch from reset vector
        step("seq1", 1, 0, 0, 0, 0, 32'd1, 0, 0, 0);
        step("seq2", 1, 0, 0, 0, 0, 32'd2, 0, 0, 0);
        step("seq3", 1, 0, 0, 0, 0, 32'd3, 0, 0, 0);
        step("seq4", 1, 0, 0, 0, 0, 32'd4, 0, 0, 0);

        // call / ret round trip
        step("jump10",  1, 1, 0, 0, 32'd10,  32'd10,  0, 0, 0);
        step("call100", 1, 0, 1, 0, 32'd100, 32'd100, 1, 0, 0);
        step("ret11",   1, 0, 0, 1, 32'd0,   32'd11,  0, 0, 0);

        // Priority: jump wins over call/ret, call wins over ret
        step("call40",  1, 0, 1, 0, 32'h40, 32'h40, 1, 0, 0);
        step("jcr50",   1, 1, 1, 1, 32'h50, 32'h50, 1, 0, 0);
        step("cr60",    1, 0, 1, 1, 32'h60, 32'h60, 2, 0, 0);
        step("ret51",   1, 0, 0, 1, 32'h0,  32'h51, 1, 0, 0);
        step("retC",    1, 0, 0, 1, 32'h0,  32'hC,  0, 0, 0);

        // Stall with call asserted
        step("stall1", 0, 0, 1, 0, 32'h99, 32'hC, 0, 0, 0);
        step("stall2", 0, 0, 1, 0, 32'h99, 32'hC, 0, 0, 0);
        step("stall3", 0, 0, 1, 0, 32'h99, 32'hC, 0, 0, 0);

        // Nested calls past depth, then unwind into underflow
        step("jump10h", 1, 1, 0, 0, 32'h10, 32'h10, 0, 0, 0);
        step("callA",   1, 0, 1, 0, 32'h11, 32'h11, 1, 0, 0);
        step("callB",   1, 0, 1, 0, 32'h12, 32'h12, 2, 0, 0);
        step("callC",   1, 0, 1, 0, 32'h13, 32'h13, 3, 0, 0);
        step("callD",   1, 0, 1, 0, 32'h14, 32'h14, 4, 0, 0);
        step("callE",   1, 0, 1, 0, 32'h15, 32'h15, 4, 1, 0);
        step("holdovf", 0, 0, 0, 1, 32'h0,  32'h15, 4, 0, 0);
        step("ret15",   1, 0, 0, 1, 32'h0,  32'h15, 3, 0, 0);
        step("ret14",   1, 0, 0, 1, 32'h0,  32'h14, 2, 0, 0);
        step("ret13",   1, 0, 0, 1, 32'h0,  32'h13, 1, 0, 0);
        step("ret12",   1, 0, 0, 1, 32'h0,  32'h12, 0, 0, 0);
        step("retunf",  1, 0, 0, 1, 32'h0,  32'h13, 0, 0, 1);
        step("postunf", 1, 0, 0, 0, 32'h0,  32'h14, 0, 0, 0);

        // 32-bit wrap
        step("jumpmax", 1, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
        step("wrap0",   1, 0, 0, 0, 32'h0,         32'h0,         0, 0, 0);

        // Asynchronous reset in the middle of a ret
        step("call200", 1, 0, 1, 0, 32'h200, 32'h200, 1, 0, 0);
        pc_ena = 1'b1; ret = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("midrst.pc",    pc_out,    32'd0);
        check("midrst.count", ras_count, 0);
        check("midrst.empty", ras_empty, 1);
        ret = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("postrst.pc", pc_out, 32'd0);
        step("postrst1", 1, 0, 0, 0, 32'h0, 32'd1, 0, 0, 0);
        step("idle",     0, 0, 0, 0, 32'h0, 32'd1, 0, 0, 0);

        // 8-bit instance: 0xFE -> 0xFF -> 0x00
        e8 = 1'b1; j8 = 1'b1; t8 = 8'hFE;
        @(posedge clk); #1;
        check("w8.jump", pc8, 8'hFE);
        @(negedge clk);
        j8 = 1'b0;
        @(posedge clk); #1;
        check("w8.pc_ff",  pc8, 8'hFF);
        check("w8.upper",  up8, 3'b111);
        check("w8.addr",   ad8, 4'hF);
        check("w8.plus",   pp8, 8'h00);
        @(posedge clk); #1;
        check("w8.wrap",   pc8, 8'h00);
        e8 = 1'b0;

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
